// File: rtl/gba_scan_scheduler.sv
// gba_scan_scheduler
// Schedules line-cache readout for the GBA upscaler from the HDMI raster
// position. Produces the GBA window flag, the source pixel index (led by
// READ_LEAD cycles to cover cache/pipeline latency), horizontal/vertical
// sub-pixel phases, the pixel-grid strobe and the line-cache strobes. HDMI
// output is held off until the first GBA frame has been captured.
//
// Ports
//   pxlClk, rst          pixel clock, synchronous active-high reset
//   cx, cy               HDMI raster position
//   frameWidth/Height    total raster size (line end / frame end detection)
//   newFrameIn           pulse: a GBA frame has been captured (starts HDMI)
//   sameLine             source line repeats; suppresses nextLine only
//   enableHdmi           HDMI core run enable
//   drawGBA              output pixel lies inside the GBA window
//   curPxl, xsel         source pixel index and horizontal phase
//   ysel, lineIdx        vertical phase and current source line
//   gridAct              pixel-grid line strobe
//   nextLine/cacheUpdate line-cache strobes
//   frameDone            pulse at the last raster pixel
//   fsmState             debug view of the FSM (0 = IDLE, 1 = RUN)
//
// Handshake: nextLine, cacheUpdate and frameDone are fire-and-forget strobes,
// exactly one cycle wide and at most once per raster line; consumers must act
// on the cycle they are high, there is no ready/back-pressure path.
// Every output is registered, one cycle after the cx/cy that caused it.

module gba_scan_scheduler #(
  parameter int SCALE     = 4,
  parameter int FRAME_W   = 1280,
  parameter int FRAME_H   = 720,
  parameter int SRC_W     = 240,
  parameter int SRC_H     = 160,
  parameter int READ_LEAD = 3
) (
  input  logic        pxlClk,
  input  logic        rst,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic [11:0] frameWidth,
  input  logic [10:0] frameHeight,
  input  logic        newFrameIn,
  input  logic        sameLine,
  output logic        enableHdmi,
  output logic        drawGBA,
  output logic [7:0]  curPxl,
  output logic [2:0]  xsel,
  output logic [2:0]  ysel,
  output logic        gridAct,
  output logic        nextLine,
  output logic        cacheUpdate,
  output logic [7:0]  lineIdx,
  output logic        frameDone,
  output logic        fsmState
);

  localparam int XSTART = (FRAME_W - SCALE * SRC_W) / 2;
  localparam int XSTOP  = XSTART + SCALE * SRC_W;
  localparam int YSTART = (FRAME_H - SCALE * SRC_H) / 2;
  localparam int YSTOP  = YSTART + SCALE * SRC_H;

  localparam logic [11:0] XSTART_C = 12'(XSTART);
  localparam logic [11:0] XSTOP_C  = 12'(XSTOP);
  // Read window is the GBA window shifted early by READ_LEAD: k in (0, SCALE*SRC_W]
  localparam logic [11:0] RD_LO_C  = 12'(XSTART - READ_LEAD);
  localparam logic [11:0] RD_HI_C  = 12'(XSTART - READ_LEAD + SCALE * SRC_W);
  localparam logic [10:0] YSTART_C = 11'(YSTART);
  localparam logic [10:0] YSTOP_C  = 11'(YSTOP);
  localparam logic [2:0]  SC_LAST  = 3'(SCALE - 1);
  localparam logic [7:0]  PX_LAST  = 8'(SRC_W - 1);
  localparam logic [7:0]  LN_LAST  = 8'(SRC_H - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        enable_q, enable_d;
  logic        draw_q, draw_d;
  logic [7:0]  cur_q, cur_d;
  logic [2:0]  xsel_q, xsel_d;
  logic [2:0]  ysel_q, ysel_d;
  logic [2:0]  gridx_q, gridx_d;
  logic        grid_q, grid_d;
  logic        nl_q, nl_d;
  logic        cu_q, cu_d;
  logic [7:0]  line_q, line_d;
  logic        fd_q, fd_d;

  logic in_x, in_y, in_rd, line_end, frame_end;

  assign in_x      = (cx >= XSTART_C) && (cx < XSTOP_C);
  assign in_y      = (cy >= YSTART_C) && (cy < YSTOP_C);
  assign in_rd     = (cx > RD_LO_C) && (cx <= RD_HI_C);
  assign line_end  = (cx == frameWidth - 12'd1);
  assign frame_end = line_end && (cy == frameHeight - 11'd1);

  always_comb begin
    // Zero defaults double as the IDLE behaviour: counters and strobes held at 0.
    state_d  = state_q;
    draw_d   = 1'b0;
    cur_d    = 8'd0;
    xsel_d   = 3'd0;
    ysel_d   = 3'd0;
    gridx_d  = 3'd0;
    grid_d   = 1'b0;
    nl_d     = 1'b0;
    cu_d     = 1'b0;
    line_d   = 8'd0;
    fd_d     = 1'b0;

    case (state_q)
      IDLE:    if (newFrameIn) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    enable_d = (state_d == RUN);

    if (state_q == RUN) begin
      draw_d = in_x && in_y;

      if (in_rd) begin
        if (xsel_q == SC_LAST) begin
          xsel_d = 3'd0;
          cur_d  = (cur_q == PX_LAST) ? cur_q : cur_q + 8'd1;
        end else begin
          xsel_d = xsel_q + 3'd1;
          cur_d  = cur_q;
        end
      end

      gridx_d = ((cx == XSTART_C) || (gridx_q == SC_LAST)) ? 3'd0 : gridx_q + 3'd1;

      ysel_d = ysel_q;
      line_d = line_q;
      if (line_end) begin
        // Frame end wins over the phase wrap so each frame starts at line 0.
        if (frame_end) begin
          ysel_d = 3'd0;
          line_d = 8'd0;
        end else if (ysel_q == SC_LAST) begin
          ysel_d = 3'd0;
          if (in_y && (line_q < LN_LAST)) line_d = line_q + 8'd1;
        end else if (cy >= YSTART_C) begin
          ysel_d = ysel_q + 3'd1;
        end
      end

      grid_d = (gridx_d == 3'd0) || (ysel_q == 3'd0);
      nl_d   = (cx == XSTOP_C) && !sameLine && in_y && (ysel_q == SC_LAST);
      cu_d   = (cx == XSTOP_C);
      fd_d   = frame_end;
    end
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      draw_q   <= 1'b0;
      cur_q    <= 8'd0;
      xsel_q   <= 3'd0;
      ysel_q   <= 3'd0;
      gridx_q  <= 3'd0;
      grid_q   <= 1'b0;
      nl_q     <= 1'b0;
      cu_q     <= 1'b0;
      line_q   <= 8'd0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      draw_q   <= draw_d;
      cur_q    <= cur_d;
      xsel_q   <= xsel_d;
      ysel_q   <= ysel_d;
      gridx_q  <= gridx_d;
      grid_q   <= grid_d;
      nl_q     <= nl_d;
      cu_q     <= cu_d;
      line_q   <= line_d;
      fd_q     <= fd_d;
    end
  end

  assign enableHdmi  = enable_q;
  assign drawGBA     = draw_q;
  assign curPxl      = cur_q;
  assign xsel        = xsel_q;
  assign ysel        = ysel_q;
  assign gridAct     = grid_q;
  assign nextLine    = nl_q;
  assign cacheUpdate = cu_q;
  assign lineIdx     = line_q;
  assign frameDone   = fd_q;
  assign fsmState    = state_q;

endmodule

// File: tb/tb_gba_scan_scheduler.sv
module tb_gba_scan_scheduler;

  // ---------------- clock / reset ----------------
  logic pxlClk = 1'b0;
  always #5 pxlClk = ~pxlClk;

  // DUT A: default parameters
  logic        rst_a, nf_a, sl_a;
  logic [11:0] cx_a, fw_a;
  logic [10:0] cy_a, fh_a;
  logic        en_a, dr_a, gr_a, nl_a, cu_a, fd_a, st_a;
  logic [7:0]  cp_a, li_a;
  logic [2:0]  xs_a, ys_a;

  // DUT B: SCALE=3 on an 858x525 raster
  logic        rst_b, nf_b, sl_b;
  logic [11:0] cx_b, fw_b;
  logic [10:0] cy_b, fh_b;
  logic        en_b, dr_b, gr_b, nl_b, cu_b, fd_b, st_b;
  logic [7:0]  cp_b, li_b;
  logic [2:0]  xs_b, ys_b;

  gba_scan_scheduler u_dut_a (
    .pxlClk(pxlClk), .rst(rst_a), .cx(cx_a), .cy(cy_a),
    .frameWidth(fw_a), .frameHeight(fh_a), .newFrameIn(nf_a), .sameLine(sl_a),
    .enableHdmi(en_a), .drawGBA(dr_a), .curPxl(cp_a), .xsel(xs_a), .ysel(ys_a),
    .gridAct(gr_a), .nextLine(nl_a), .cacheUpdate(cu_a), .lineIdx(li_a),
    .frameDone(fd_a), .fsmState(st_a)
  );

  gba_scan_scheduler #(.SCALE(3), .FRAME_W(858), .FRAME_H(525)) u_dut_b (
    .pxlClk(pxlClk), .rst(rst_b), .cx(cx_b), .cy(cy_b),
    .frameWidth(fw_b), .frameHeight(fh_b), .newFrameIn(nf_b), .sameLine(sl_b),
    .enableHdmi(en_b), .drawGBA(dr_b), .curPxl(cp_b), .xsel(xs_b), .ysel(ys_b),
    .gridAct(gr_b), .nextLine(nl_b), .cacheUpdate(cu_b), .lineIdx(li_b),
    .frameDone(fd_b), .fsmState(st_b)
  );

  // Packed output layout: en, draw, curPxl, xsel, ysel, grid, nextLine, cacheUpdate, lineIdx, frameDone
  localparam logic [27:0] M_EN  = 28'h8000000;
  localparam logic [27:0] M_DR  = 28'h4000000;
  localparam logic [27:0] M_CP  = 28'h3FC0000;
  localparam logic [27:0] M_XS  = 28'h0038000;
  localparam logic [27:0] M_YS  = 28'h0007000;
  localparam logic [27:0] M_GR  = 28'h0000800;
  localparam logic [27:0] M_NL  = 28'h0000400;
  localparam logic [27:0] M_CU  = 28'h0000200;
  localparam logic [27:0] M_LI  = 28'h00001FE;
  localparam logic [27:0] M_FD  = 28'h0000001;
  localparam logic [27:0] M_ALL = 28'hFFFFFFF;

  function automatic logic [27:0] pk(input logic en, input logic dr, input logic [7:0] cp,
                                     input logic [2:0] xs, input logic [2:0] ys, input logic gr,
                                     input logic nl, input logic cu, input logic [7:0] li,
                                     input logic fd);
    return {en, dr, cp, xs, ys, gr, nl, cu, li, fd};
  endfunction

  // ---------------- scoreboard ----------------
  logic [28:0] exp_q[$];   // bit 28 selects DUT B
  logic [27:0] msk_q[$];
  int          tag_q[$];
  int          total = 0;
  int          bad   = 0;
  int          nl_cnt = 0;

  task automatic chk(input string nm, input logic [27:0] a, input logic [27:0] e,
                     input logic [27:0] m, input logic [27:0] fm, input int sh,
                     input int tag, input logic sel);
    logic [27:0] mm;
    mm = m & fm;
    if (mm != 28'd0) begin
      total++;
      if ((a & mm) !== (e & mm)) begin
        bad++;
        $display("FAIL %s dut%s cx=%0d cy=%0d got=%0d want=%0d", nm, sel ? "B" : "A",
                 tag % 4096, tag / 4096, (a & mm) >> sh, (e & mm) >> sh);
      end
    end
  endtask

  logic [28:0] mon_ent;
  logic [27:0] mon_msk, mon_act;
  int          mon_tag;

  always @(posedge pxlClk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_ent = exp_q.pop_front();
      mon_msk = msk_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = mon_ent[28] ? pk(en_b, dr_b, cp_b, xs_b, ys_b, gr_b, nl_b, cu_b, li_b, fd_b)
                            : pk(en_a, dr_a, cp_a, xs_a, ys_a, gr_a, nl_a, cu_a, li_a, fd_a);
      if (!mon_ent[28] && nl_a) nl_cnt++;
      chk("enableHdmi",  mon_act, mon_ent[27:0], mon_msk, M_EN, 27, mon_tag, mon_ent[28]);
      chk("drawGBA",     mon_act, mon_ent[27:0], mon_msk, M_DR, 26, mon_tag, mon_ent[28]);
      chk("curPxl",      mon_act, mon_ent[27:0], mon_msk, M_CP, 18, mon_tag, mon_ent[28]);
      chk("xsel",        mon_act, mon_ent[27:0], mon_msk, M_XS, 15, mon_tag, mon_ent[28]);
      chk("ysel",        mon_act, mon_ent[27:0], mon_msk, M_YS, 12, mon_tag, mon_ent[28]);
      chk("gridAct",     mon_act, mon_ent[27:0], mon_msk, M_GR, 11, mon_tag, mon_ent[28]);
      chk("nextLine",    mon_act, mon_ent[27:0], mon_msk, M_NL, 10, mon_tag, mon_ent[28]);
      chk("cacheUpdate", mon_act, mon_ent[27:0], mon_msk, M_CU,  9, mon_tag, mon_ent[28]);
      chk("lineIdx",     mon_act, mon_ent[27:0], mon_msk, M_LI,  1, mon_tag, mon_ent[28]);
      chk("frameDone",   mon_act, mon_ent[27:0], mon_msk, M_FD,  0, mon_tag, mon_ent[28]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sel, input int x, input int y, input logic r,
                       input logic nf, input logic sl, input logic [27:0] m, input logic [27:0] e);
    @(negedge pxlClk);
    if (!sel) begin
      rst_a = r; cx_a = 12'(x); cy_a = 11'(y); nf_a = nf; sl_a = sl;
    end else begin
      rst_b = r; cx_b = 12'(x); cy_b = 11'(y); nf_b = nf; sl_b = sl;
    end
    exp_q.push_back({sel, e});
    msk_q.push_back(m);
    tag_q.push_back(y * 4096 + x);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge pxlClk);
      #2;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
  endtask

  // Hand-derived frame expectations at the defaults (YSTART=40, YSTOP=680, SCALE=4)
  function automatic logic [2:0] ys_after(input int y);
    if (y == 719 || y < 40) return 3'd0;
    return 3'((y - 39) % 4);
  endfunction

  function automatic logic [7:0] li_after(input int y);
    int v;
    if (y == 719 || y < 43) return 8'd0;
    v = (y - 43) / 4 + 1;
    if (v > 159) v = 159;
    return 8'(v);
  endfunction

  function automatic logic nl_line(input int y);
    return (y >= 43) && (y <= 679) && ((y - 43) % 4 == 0);
  endfunction

  // Line-end region of one raster line on DUT A
  task automatic run_line(input int y, input logic sl);
    logic dr;
    dr = (y >= 40) && (y < 680);
    drive(1'b0, 1119, y, 1'b0, 1'b0, sl, M_DR | M_NL | M_CU, pk(0, dr, 8'd0, 3'd0, 3'd0, 0, 0, 0, 8'd0, 0));
    drive(1'b0, 1120, y, 1'b0, 1'b0, sl, M_DR | M_NL | M_CU | M_CP | M_XS,
          pk(0, 0, 8'd0, 3'd0, 3'd0, 0, nl_line(y) && !sl, 1, 8'd0, 0));
    drive(1'b0, 1121, y, 1'b0, 1'b0, sl, M_NL | M_CU, 28'd0);
    drive(1'b0, 1279, y, 1'b0, 1'b0, sl, M_YS | M_LI | M_FD | M_NL | M_CU,
          pk(0, 0, 8'd0, 3'd0, ys_after(y), 0, 0, 0, li_after(y), y == 719));
  endtask

  // SCALE=3 line sweep on DUT B: XSTART=69, read window starts at cx=67
  task automatic sweep_b(input int y, input logic ysel_zero);
    logic [27:0] m;
    logic [7:0]  cp;
    logic [2:0]  xs;
    logic        dr, gr;
    for (int x = 60; x <= 100; x++) begin
      m = 28'd0; cp = 8'd0; xs = 3'd0; dr = 1'b0; gr = 1'b0;
      case (x)
        66: begin m = M_CP | M_XS | M_DR; end
        67: begin m = M_XS; xs = 3'd1; end
        68: begin m = M_XS | M_DR; xs = 3'd2; end
        69: begin m = M_CP | M_XS | M_DR | M_GR; cp = 8'd1; dr = 1'b1; gr = 1'b1; end
        70: begin m = M_GR; gr = ysel_zero; end
        71: begin m = M_GR; gr = ysel_zero; end
        72: begin m = M_CP | M_XS | M_GR; cp = 8'd2; gr = 1'b1; end
        73: begin m = M_GR; gr = ysel_zero; end
        75: begin m = M_CP | M_GR; cp = 8'd3; gr = 1'b1; end
        default: m = 28'd0;
      endcase
      drive(1'b1, x, y, 1'b0, 1'b0, 1'b0, m, pk(0, dr, cp, xs, 3'd0, gr, 0, 0, 8'd0, 0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [27:0] m;
    logic [7:0]  cp;
    logic [2:0]  xs;
    logic        dr, cu;

    rst_a = 1'b1; nf_a = 1'b0; sl_a = 1'b0; cx_a = '0; cy_a = '0; fw_a = 12'd1280; fh_a = 11'd720;
    rst_b = 1'b1; nf_b = 1'b0; sl_b = 1'b0; cx_b = '0; cy_b = '0; fw_b = 12'd858;  fh_b = 11'd525;

    // Reset held with newFrameIn high: everything stays 0
    repeat (3) drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, M_ALL, 28'd0);
    repeat (2) drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, M_ALL, 28'd0);
    // newFrameIn starts HDMI; the first RUN cycle shows gridAct because ysel==0
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, M_ALL, M_EN);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, M_ALL, M_EN | M_GR);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, M_EN, M_EN);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, M_EN, M_EN);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, M_EN, M_EN);

    // Horizontal sweep on cy=40
    for (int x = 150; x <= 1130; x++) begin
      m = 28'd0; cp = 8'd0; xs = 3'd0; dr = 1'b0; cu = 1'b0;
      case (x)
        157:  m = M_CP | M_XS | M_DR;
        158:  begin m = M_CP | M_XS; xs = 3'd1; end
        159:  begin m = M_XS | M_DR; xs = 3'd2; end
        160:  begin m = M_XS | M_DR; xs = 3'd3; dr = 1'b1; end
        161:  begin m = M_CP | M_XS; cp = 8'd1; end
        165:  begin m = M_CP | M_XS; cp = 8'd2; end
        1113: begin m = M_CP | M_XS; cp = 8'd239; end
        1116: begin m = M_CP | M_XS; cp = 8'd239; xs = 3'd3; end
        1117: begin m = M_CP | M_XS; cp = 8'd239; end
        1118: m = M_CP | M_XS;
        1119: begin m = M_DR | M_CU | M_NL; dr = 1'b1; end
        1120: begin m = M_DR | M_CU | M_NL; cu = 1'b1; end
        1121: m = M_CU;
        default: m = 28'd0;
      endcase
      drive(1'b0, x, 40, 1'b0, 1'b0, 1'b0, m, pk(0, dr, cp, xs, 3'd0, 0, 0, cu, 8'd0, 0));
    end
    drain();

    // Full frame, line-end regions only
    nl_cnt = 0;
    for (int y = 0; y < 720; y++) run_line(y, 1'b0);
    drain();
    total++;
    if (nl_cnt != 160) begin
      bad++;
      $display("FAIL nextLine_count got=%0d want=160", nl_cnt);
    end

    // sameLine on cy=43: no nextLine, cacheUpdate and ysel wrap unaffected
    for (int y = 0; y <= 44; y++) run_line(y, y == 43);

    // Mid-frame reset at cy=300
    drive(1'b0, 500, 300, 1'b0, 1'b0, 1'b0, M_EN | M_DR, M_EN | M_DR);
    drive(1'b0, 1120, 300, 1'b1, 1'b0, 1'b0, M_ALL, 28'd0);
    drive(1'b0, 1120, 300, 1'b0, 1'b0, 1'b0, M_ALL, 28'd0);
    drive(1'b0, 1279, 719, 1'b0, 1'b0, 1'b0, M_ALL, 28'd0);
    drive(1'b0, 1120, 43, 1'b0, 1'b0, 1'b0, M_ALL, 28'd0);
    drive(1'b0, 1120, 300, 1'b0, 1'b1, 1'b0, M_ALL, M_EN);
    drive(1'b0, 1120, 300, 1'b0, 1'b0, 1'b0, M_ALL, M_EN | M_CU | M_GR);

    // SCALE=3 instance
    drive(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, M_ALL, 28'd0);
    drive(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, M_ALL, M_EN);
    sweep_b(22, 1'b1);
    drive(1'b1, 857, 22, 1'b0, 1'b0, 1'b0, M_YS | M_LI | M_FD,
          pk(0, 0, 8'd0, 3'd0, 3'd1, 0, 0, 0, 8'd0, 0));
    sweep_b(23, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
